ahb_fifo_wr_packer: RTL and testbench



---
 rtl/ahb_fifo_wr_packer.sv | 116 +++++++++++
 tb/tb_ahb_fifo_wr_packer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_fifo_wr_packer.sv
// ahb_fifo_wr_packer
// AHB-Lite slave front-end on the write side of the bridge's async command
// FIFO. Each accepted transfer becomes one command word {rw, addr, data},
// pushed to the FIFO in the same cycle as its AHB data phase completes.
// Wait states are inserted while the FIFO reports full.
//
// Optional build macro: AHB_ERROR_RESP_EN
//   Defined  : transfers with hsize != word or haddr[1:0] != 0 get a
//              two-cycle ERROR response and are not pushed.
//   Undefined: no size/alignment check; hresp is tied to OKAY.
//
// Ports
//   wr_clk, wr_rst_n    write-domain clock, async active-low reset
//   hsel .. hready      AHB-Lite slave inputs
//   hreadyout, hresp    AHB slave response
//   hrdata              read data (always 0)
//   wr_en, wr_data      FIFO write port
//   full                FIFO full flag
//   stall_cnt           saturating count of full-induced wait states
module ahb_fifo_wr_packer #(
  parameter int DATA_WIDTH  = 41,
  parameter int ADDR_BITS   = 8,
  parameter int HDATA_WIDTH = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   wr_clk,
  input  logic                   wr_rst_n,
  input  logic                   hsel,
  input  logic [31:0]            haddr,
  input  logic [1:0]             htrans,
  input  logic                   hwrite,
  input  logic [2:0]             hsize,
  input  logic [HDATA_WIDTH-1:0] hwdata,
  input  logic                   hready,
  output logic                   hreadyout,
  output logic                   hresp,
  output logic [HDATA_WIDTH-1:0] hrdata,
  output logic                   wr_en,
  output logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   full,
  output logic [CNT_WIDTH-1:0]   stall_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

  state_t                 state;
  logic                   hwrite_q;
  logic [ADDR_BITS-1:0]   haddr_q;
  logic                   accept;
  logic                   bad_xfer;
  state_t                 accept_state;

  assign accept = hsel & hready & htrans[1];

`ifdef AHB_ERROR_RESP_EN
  assign bad_xfer = (hsize != 3'b010) || (haddr[1:0] != 2'b00);
  assign hresp    = (state == ERR1) || (state == ERR2);
`else
  assign bad_xfer = 1'b0;
  assign hresp    = 1'b0;
`endif

  assign accept_state = bad_xfer ? ERR1 : DATA;

  // Upper address bits, the SEQ/NONSEQ distinction and (in the default
  // build) hsize carry no information for this slave.
  logic unused_inputs;
  assign unused_inputs = ^{haddr[31:ADDR_BITS], htrans[0], hsize};

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state     <= IDLE;
      hwrite_q  <= 1'b0;
      haddr_q   <= '0;
      stall_cnt <= '0;
    end else begin
      unique case (state)
        IDLE, ERR2: begin
          if (accept) begin
            hwrite_q <= hwrite;
            haddr_q  <= haddr[ADDR_BITS-1:0];
            state    <= accept_state;
          end else begin
            state    <= IDLE;
          end
        end
        DATA: begin
          if (full) begin
            if (stall_cnt != '1)
              stall_cnt <= stall_cnt + CNT_WIDTH'(1);
          end else if (accept) begin
            // Push of the current word and capture of the next address
            // phase share this edge: one push per cycle back-to-back.
            hwrite_q <= hwrite;
            haddr_q  <= haddr[ADDR_BITS-1:0];
            state    <= accept_state;
          end else begin
            state    <= IDLE;
          end
        end
        ERR1:    state <= ERR2;
        default: state <= IDLE;
      endcase
    end
  end

  // Push and AHB completion coincide, so the FIFO write strobe is driven
  // combinationally from full rather than delayed a cycle.
  assign wr_en     = (state == DATA) && !full;
  assign wr_data   = wr_en ? DATA_WIDTH'({hwrite_q, haddr_q,
                                          hwrite_q ? hwdata : {HDATA_WIDTH{1'b0}}})
                           : '0;
  assign hreadyout = (state == DATA) ? !full : (state != ERR1);
  assign hrdata    = '0;

endmodule

// File: tb/tb_ahb_fifo_wr_packer.sv
module tb_ahb_fifo_wr_packer;

  logic        wr_clk = 1'b0;
  logic        wr_rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        wr_en;
  logic [40:0] wr_data;
  logic        full;
  logic [15:0] stall_cnt;

  // Single-slave bus: the interconnect returns our own hreadyout.
  assign hready = hreadyout;

  always #5 wr_clk = ~wr_clk;

  ahb_fifo_wr_packer dut (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .hsel(hsel), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hready(hready), .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .stall_cnt(stall_cnt)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Transfer list consumed by the bus driver.
  int          n_tx;
  logic [31:0] tx_addr  [64];
  logic [31:0] tx_data  [64];
  logic [1:0]  tx_trans [64];
  logic        tx_write [64];
  logic [2:0]  tx_size  [64];
  int          tx_stall [64];

  // Observations collected by the driver.
  logic [40:0] obs_words[$];
  int          obs_cyc[$];
  int          obs_waits;
  int          obs_err;
  int          obs_rdata_bad;
  bit          timed_out;

  // Model state.
  logic [40:0] exp_words[$];
  int          exp_waits;
  int          exp_err;
  int          exp_stall;

  function automatic logic [40:0] pack(logic w, logic [31:0] a, logic [31:0] d);
    return {w, a[7:0], (w ? d : 32'h0)};
  endfunction

  function automatic bit xfer_ok(logic [2:0] sz, logic [31:0] a);
`ifdef AHB_ERROR_RESP_EN
    return (sz == 3'b010) && (a[1:0] == 2'b00);
`else
    return 1'b1;
`endif
  endfunction

  // Expected results from the transfer list: every active transfer that
  // passes the size/alignment rule is one push; its stall cycles are both
  // wait states and stall-counter increments; a rejected transfer costs one
  // wait state and two ERROR cycles.
  task automatic build_model();
    exp_words.delete();
    exp_waits = 0;
    exp_err   = 0;
    for (int i = 0; i < n_tx; i++) begin
      if (tx_trans[i][1]) begin
        if (xfer_ok(tx_size[i], tx_addr[i])) begin
          exp_words.push_back(pack(tx_write[i], tx_addr[i], tx_data[i]));
          exp_waits += tx_stall[i];
          exp_stall += tx_stall[i];
        end else begin
          exp_waits += 1;
          exp_err   += 2;
        end
      end
    end
  endtask

  task automatic add_tx(logic [1:0] tr, logic w, logic [31:0] a, logic [31:0] d,
                        logic [2:0] sz, int st);
    tx_trans[n_tx] = tr;
    tx_write[n_tx] = w;
    tx_addr[n_tx]  = a;
    tx_data[n_tx]  = d;
    tx_size[n_tx]  = sz;
    tx_stall[n_tx] = st;
    n_tx++;
  endtask

  // Pipelined AHB master: address phase of transfer i+1 overlaps the data
  // phase of transfer i; full is held high for tx_stall cycles of each data
  // phase and is random noise when no data phase is in progress.
  task automatic run_txns();
    int          idx = 0;
    bit          dact = 0;
    logic [31:0] ddata = '0;
    int          sleft = 0;
    int          cyc = 0;
    obs_words.delete();
    obs_cyc.delete();
    obs_waits = 0;
    obs_err = 0;
    obs_rdata_bad = 0;
    timed_out = 0;
    while ((idx < n_tx || dact) && !timed_out) begin
      @(posedge wr_clk); #1;
      full   = dact ? (sleft > 0) : 1'($urandom_range(0, 1));
      hwdata = dact ? ddata : $urandom();
      if (idx < n_tx) begin
        hsel = 1'b1; htrans = tx_trans[idx]; haddr = tx_addr[idx];
        hwrite = tx_write[idx]; hsize = tx_size[idx];
      end else begin
        hsel = 1'($urandom_range(0, 1)); htrans = 2'b00; haddr = $urandom();
        hwrite = 1'($urandom_range(0, 1)); hsize = 3'b010;
      end
      @(negedge wr_clk);
      if (wr_en === 1'b1) begin
        obs_words.push_back(wr_data);
        obs_cyc.push_back(cyc);
      end
      if (hreadyout !== 1'b1) obs_waits++;
      if (hresp !== 1'b0) obs_err++;
      if (hrdata !== 32'h0) obs_rdata_bad++;
      if (hreadyout === 1'b1) begin
        if (idx < n_tx) begin
          dact  = tx_trans[idx][1];
          ddata = tx_data[idx];
          sleft = tx_stall[idx];
          idx++;
        end else begin
          dact = 0;
        end
      end else if (sleft > 0) begin
        sleft--;
      end
      cyc++;
      if (cyc > 2000) timed_out = 1;
    end
    @(posedge wr_clk); #1;
    full = 1'b0; hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic do_reset();
    wr_rst_n = 1'b0;
    hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010;
    hwdata = '0; full = 1'b0;
    repeat (3) @(posedge wr_clk);
    #1 wr_rst_n = 1'b1;
    exp_stall = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge wr_clk);
    total_cnt++; if (hreadyout !== 1'b1) $display("FAIL reset_hreadyout got %b want 1", hreadyout); else pass_cnt++;
    total_cnt++; if (hresp !== 1'b0) $display("FAIL reset_hresp got %b want 0", hresp); else pass_cnt++;
    total_cnt++; if (hrdata !== 32'h0) $display("FAIL reset_hrdata got %h want 0", hrdata); else pass_cnt++;
    total_cnt++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", wr_en); else pass_cnt++;
    total_cnt++; if (wr_data !== 41'h0) $display("FAIL reset_wr_data got %h want 0", wr_data); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'h0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_single_write();
    n_tx = 0;
    add_tx(2'b10, 1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 3'b010, 0);
    build_model();
    run_txns();
    total_cnt++; if (timed_out || obs_words.size() != 1) $display("FAIL single_push_count got %0d want 1", obs_words.size()); else pass_cnt++;
    total_cnt++; if (obs_words.size() < 1 || obs_words[0] !== {1'b1, 8'h14, 32'hDEAD_BEEF}) $display("FAIL single_word got %h want %h", (obs_words.size() > 0) ? obs_words[0] : 41'h0, {1'b1, 8'h14, 32'hDEAD_BEEF}); else pass_cnt++;
    total_cnt++; if (obs_waits != 0) $display("FAIL single_waits got %0d want 0", obs_waits); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL single_stall_cnt got %0d want %0d", stall_cnt, exp_stall); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    n_tx = 0;
    for (int i = 0; i < 4; i++)
      add_tx((i == 0) ? 2'b10 : 2'b11, 1'b1, 32'(i * 4), $urandom(), 3'b010, 0);
    build_model();
    run_txns();
    total_cnt++; if (timed_out || obs_words.size() != 4) $display("FAIL b2b_push_count got %0d want 4", obs_words.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < obs_words.size(); i++) begin
      total_cnt++; if (obs_words[i] !== exp_words[i]) $display("FAIL b2b_word%0d got %h want %h", i, obs_words[i], exp_words[i]); else pass_cnt++;
      total_cnt++; if (obs_cyc[i] != obs_cyc[0] + i) $display("FAIL b2b_cycle%0d got %0d want %0d", i, obs_cyc[i], obs_cyc[0] + i); else pass_cnt++;
    end
    total_cnt++; if (obs_waits != 0) $display("FAIL b2b_waits got %0d want 0", obs_waits); else pass_cnt++;
  endtask

  task automatic test_full_stall();
    n_tx = 0;
    add_tx(2'b10, 1'b1, 32'h0000_0020, $urandom(), 3'b010, 3);
    build_model();
    run_txns();
    total_cnt++; if (timed_out || obs_words.size() != 1) $display("FAIL stall_push_count got %0d want 1", obs_words.size()); else pass_cnt++;
    total_cnt++; if (obs_words.size() < 1 || obs_words[0] !== exp_words[0]) $display("FAIL stall_word got %h want %h", (obs_words.size() > 0) ? obs_words[0] : 41'h0, exp_words[0]); else pass_cnt++;
    total_cnt++; if (obs_waits != 3) $display("FAIL stall_waits got %0d want 3", obs_waits); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'd3) $display("FAIL stall_cnt got %0d want 3", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_read_idle_busy();
    n_tx = 0;
    add_tx(2'b10, 1'b0, 32'h0000_003C, $urandom(), 3'b010, 0);
    add_tx(2'b00, 1'b1, 32'h0000_0040, $urandom(), 3'b010, 0);
    add_tx(2'b01, 1'b1, 32'h0000_0044, $urandom(), 3'b010, 0);
    build_model();
    run_txns();
    total_cnt++; if (timed_out || obs_words.size() != 1) $display("FAIL read_push_count got %0d want 1", obs_words.size()); else pass_cnt++;
    total_cnt++; if (obs_words.size() < 1 || obs_words[0] !== {1'b0, 8'h3C, 32'h0}) $display("FAIL read_word got %h want %h", (obs_words.size() > 0) ? obs_words[0] : 41'h0, {1'b0, 8'h3C, 32'h0}); else pass_cnt++;
    total_cnt++; if (obs_err != 0) $display("FAIL read_hresp got %0d error cycles want 0", obs_err); else pass_cnt++;
    total_cnt++; if (obs_rdata_bad != 0) $display("FAIL read_hrdata got %0d nonzero cycles want 0", obs_rdata_bad); else pass_cnt++;
  endtask

  task automatic test_size_align();
    logic [31:0] d;
    d = $urandom();
    n_tx = 0;
    add_tx(2'b10, 1'b1, 32'h0000_0001, d, 3'b000, 0);
    add_tx(2'b10, 1'b1, 32'h0000_0008, 32'h1234_5678, 3'b010, 0);
    build_model();
    run_txns();
`ifdef AHB_ERROR_RESP_EN
    total_cnt++; if (timed_out || obs_words.size() != 1) $display("FAIL err_push_count got %0d want 1", obs_words.size()); else pass_cnt++;
    total_cnt++; if (obs_err != 2) $display("FAIL err_hresp_cycles got %0d want 2", obs_err); else pass_cnt++;
    total_cnt++; if (obs_waits != 1) $display("FAIL err_waits got %0d want 1", obs_waits); else pass_cnt++;
    total_cnt++; if (obs_words.size() < 1 || obs_words[0] !== {1'b1, 8'h08, 32'h1234_5678}) $display("FAIL err_next_word got %h want %h", (obs_words.size() > 0) ? obs_words[0] : 41'h0, {1'b1, 8'h08, 32'h1234_5678}); else pass_cnt++;
`else
    total_cnt++; if (timed_out || obs_words.size() != 2) $display("FAIL byte_push_count got %0d want 2", obs_words.size()); else pass_cnt++;
    total_cnt++; if (obs_words.size() < 1 || obs_words[0] !== {1'b1, 8'h01, d}) $display("FAIL byte_word got %h want %h", (obs_words.size() > 0) ? obs_words[0] : 41'h0, {1'b1, 8'h01, d}); else pass_cnt++;
    total_cnt++; if (obs_err != 0) $display("FAIL byte_hresp_cycles got %0d want 0", obs_err); else pass_cnt++;
`endif
  endtask

  task automatic test_random();
    int ncmp;
    n_tx = 0;
    for (int i = 0; i < 48; i++) begin
      logic [1:0]  tr;
      logic [2:0]  sz;
      logic [31:0] a;
      tr = 2'($urandom_range(0, 3));
      sz = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 2)) : 3'b010;
      a  = $urandom();
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      add_tx(tr, 1'($urandom_range(0, 1)), a, $urandom(), sz,
             xfer_ok(sz, a) ? $urandom_range(0, 3) : 0);
    end
    build_model();
    run_txns();
    total_cnt++; if (timed_out || obs_words.size() != exp_words.size()) $display("FAIL rand_push_count got %0d want %0d", obs_words.size(), exp_words.size()); else pass_cnt++;
    ncmp = (obs_words.size() < exp_words.size()) ? obs_words.size() : exp_words.size();
    for (int i = 0; i < ncmp; i++) begin
      total_cnt++; if (obs_words[i] !== exp_words[i]) $display("FAIL rand_word%0d got %h want %h", i, obs_words[i], exp_words[i]); else pass_cnt++;
    end
    total_cnt++; if (obs_waits != exp_waits) $display("FAIL rand_waits got %0d want %0d", obs_waits, exp_waits); else pass_cnt++;
    total_cnt++; if (obs_err != exp_err) $display("FAIL rand_hresp_cycles got %0d want %0d", obs_err, exp_err); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'(exp_stall)) $display("FAIL rand_stall_cnt got %0d want %0d", stall_cnt, exp_stall); else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    int pushes = 0;
    @(posedge wr_clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0000_0030; hsize = 3'b010;
    @(posedge wr_clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = $urandom(); full = 1'b1;
    repeat (2) @(posedge wr_clk);
    @(negedge wr_clk);
    total_cnt++; if (hreadyout !== 1'b0) $display("FAIL rst_pre_hreadyout got %b want 0", hreadyout); else pass_cnt++;
    // Drop full together with reset: a surviving DATA state would push.
    wr_rst_n = 1'b0; full = 1'b0;
    #1;
    total_cnt++; if (wr_en !== 1'b0) $display("FAIL rst_wr_en got %b want 0", wr_en); else pass_cnt++;
    total_cnt++; if (hreadyout !== 1'b1) $display("FAIL rst_hreadyout got %b want 1", hreadyout); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'h0) $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); else pass_cnt++;
    exp_stall = 0;
    @(posedge wr_clk); #1 wr_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge wr_clk);
      if (wr_en === 1'b1) pushes++;
    end
    total_cnt++; if (pushes != 0) $display("FAIL rst_no_push got %0d want 0", pushes); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_full_stall();
    test_read_idle_busy();
    test_size_align();
    test_random();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
